// File: rtl/alu_seg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seg_pipe
//  Brief    : Registered W-bit ALU (8 opcodes, carry/zero flags) behind
//             valid/ready handshakes, with an NDIG-digit active-low hex
//             7-segment display of the registered result.
//             Optional macro ALU_SAT_EN: ADD saturates to all-ones on carry,
//             SUB saturates to zero on borrow (carry flag still reports it).
//  Revision : 1.0  initial release
// ============================================================================
module alu_seg_pipe #(
    parameter int W    = 8,
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      result,
    output logic              carry,
    output logic              zero,
    output logic [7*NDIG-1:0] hex
);

    localparam logic [6:0]        c_SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]        c_SEG_BLANK = 7'b1111111;
    localparam logic [7*NDIG-1:0] c_HEX_RST   = {NDIG{c_SEG_ZERO}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [2:0]         r_op_q, w_op_d;
    logic [W-1:0]       r_a_q, w_a_d;
    logic [W-1:0]       r_b_q, w_b_d;
    logic [W-1:0]       r_result_q, w_result_d;
    logic               r_carry_q, w_carry_d;
    logic               r_zero_q, w_zero_d;
    logic [7*NDIG-1:0]  r_hex_q, w_hex_d;

    logic [W:0]         w_sum;
    logic [W:0]         w_diff;
    logic [W-1:0]       w_alu_res;
    logic               w_alu_carry;
    logic [7*NDIG-1:0]  w_alu_hex;

    // Active-low {g..a} glyph for one hex nibble
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign w_sum  = {1'b0, r_a_q} + {1'b0, r_b_q};
    // MSB of the widened difference is the borrow (set iff a < b)
    assign w_diff = {1'b0, r_a_q} - {1'b0, r_b_q};

    // ALU datapath on the captured operands
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_op_q)
            3'b000: w_alu_res = ~r_a_q;
            3'b001: w_alu_res = r_a_q & r_b_q;
            3'b010: w_alu_res = r_a_q | r_b_q;
            3'b011: begin
                w_alu_res   = w_sum[W-1:0];
                w_alu_carry = w_sum[W];
`ifdef ALU_SAT_EN
                if (w_sum[W]) w_alu_res = '1;
`endif
            end
            3'b100: w_alu_res = r_a_q ^ r_b_q;
            3'b101: begin
                w_alu_res   = w_diff[W-1:0];
                w_alu_carry = w_diff[W];
`ifdef ALU_SAT_EN
                if (w_diff[W]) w_alu_res = '0;
`endif
            end
            3'b110: w_alu_res = {r_a_q[W-2:0], 1'b0};
            default: w_alu_res = {1'b0, r_a_q[W-1:1]};
        endcase
    end

    // Digits covering the result show its nibbles; any extra digits are blank
    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_dig
            if (k < W/4) begin : g_val
                assign w_alu_hex[7*k +: 7] = f_glyph(w_alu_res[4*k +: 4]);
            end else begin : g_blank
                assign w_alu_hex[7*k +: 7] = c_SEG_BLANK;
            end
        end
    endgenerate

    // Next-state: capture in IDLE, register results in EXEC, wait in HOLD
    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_zero_d   = r_zero_q;
        w_hex_d    = r_hex_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_op_d    = opcode;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_result_d = w_alu_res;
                w_carry_d  = w_alu_carry;
                w_zero_d   = (w_alu_res == '0);
                w_hex_d    = w_alu_hex;
                w_state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset discards any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_op_q     <= 3'b000;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_zero_q   <= 1'b0;
            r_hex_q    <= c_HEX_RST;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_zero_q   <= w_zero_d;
            r_hex_q    <= w_hex_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = (r_state_q == ST_HOLD);
    assign result    = r_result_q;
    assign carry     = r_carry_q;
    assign zero      = r_zero_q;
    assign hex       = r_hex_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seg_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seg_pipe
//  Brief    : Self-checking bench for alu_seg_pipe (W=8, NDIG=3): directed
//             literal cases, backpressure, async reset, random traffic against
//             a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seg_pipe;

    localparam int W    = 8;
    localparam int NDIG = 3;
    localparam logic [7*NDIG-1:0] c_HEX_RST = {NDIG{7'b1000000}};

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      result;
    logic              carry;
    logic              zero;
    logic [7*NDIG-1:0] hex;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    alu_seg_pipe #(.W(W), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .hex       (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] glyph_tab [16];
    initial begin
        glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
        glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
        glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
        glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
        glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
        glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
    end

    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux = x;
        longint uy = y;
        longint m  = longint'(1) << W;
        longint r;
        case (op)
            3'd0: r = (m - 1) - ux;
            3'd1: r = longint'(x & y);
            3'd2: r = longint'(x | y);
            3'd3: begin
                r = (ux + uy) % m;
`ifdef ALU_SAT_EN
                if (ux + uy >= m) r = m - 1;
`endif
            end
            3'd4: r = longint'(x ^ y);
            3'd5: begin
                r = (ux - uy + m) % m;
`ifdef ALU_SAT_EN
                if (ux < uy) r = 0;
`endif
            end
            3'd6: r = (ux * 2) % m;
            default: r = ux / 2;
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic ref_carry(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux = x;
        longint uy = y;
        if (op == 3'd3) return (ux + uy) >= (longint'(1) << W);
        if (op == 3'd5) return ux < uy;
        return 1'b0;
    endfunction

    function automatic logic [7*NDIG-1:0] ref_hex(input logic [W-1:0] r);
        logic [7*NDIG-1:0] h;
        for (int k = 0; k < NDIG; k++) begin
            if (k < W/4) h[7*k +: 7] = glyph_tab[(r >> (4*k)) & 4'hF];
            else         h[7*k +: 7] = 7'b1111111;
        end
        return h;
    endfunction

    function automatic logic [7*NDIG-1:0] mk3(input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
        return {d2, d1, d0};
    endfunction

    // Model: one operation at a time, visible one edge after acceptance,
    // held until the consumer takes it
    logic              m_busy, m_valid, m_c, m_z, p_c;
    logic [W-1:0]      m_res, p_res;
    logic [7*NDIG-1:0] m_hex;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_res <= '0; m_c <= 1'b0;
            m_z <= 1'b0; m_hex <= c_HEX_RST; p_res <= '0; p_c <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                p_res  <= ref_res(opcode, a, b);
                p_c    <= ref_carry(opcode, a, b);
            end
        end else if (!m_valid) begin
            m_valid <= 1'b1;
            m_res   <= p_res;
            m_c     <= p_c;
            m_z     <= (p_res == '0);
            m_hex   <= ref_hex(p_res);
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.in_ready",  64'(in_ready),  64'(!m_busy));
            chk("m.out_valid", 64'(out_valid), 64'(m_valid));
            chk("m.result",    64'(result),    64'(m_res));
            chk("m.carry",     64'(carry),     64'(m_c));
            chk("m.zero",      64'(zero),      64'(m_z));
            chk("m.hex",       64'(hex),       64'(m_hex));
        end
    end

    // Directed op with literal expectations and latency check
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ec, input logic ez,
                         input logic [7*NDIG-1:0] eh, input string tag);
        int n;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = x; b = y; out_ready = 1'b0;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; opcode = ~op;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd2);
        chk({tag, ".result"},  64'(result), 64'(er));
        chk({tag, ".carry"},   64'(carry),  64'(ec));
        chk({tag, ".zero"},    64'(zero),   64'(ez));
        chk({tag, ".hex"},     64'(hex),    64'(eh));
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result",    64'(result),    64'd0);
        chk("rst.hex",       64'(hex),       64'(c_HEX_RST));
        @(negedge clk); rst_n = 1'b1; cmp_en = 1'b1;

`ifdef ALU_SAT_EN
        do_op(3'b011, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b0, mk3(7'h7F, 7'b0001110, 7'b0001110), "add_ovf");
        do_op(3'b101, 8'h03, 8'h05, 8'h00, 1'b1, 1'b1, mk3(7'h7F, 7'b1000000, 7'b1000000), "sub_brw");
`else
        do_op(3'b011, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, mk3(7'h7F, 7'b1111001, 7'b1000000), "add_ovf");
        do_op(3'b101, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, mk3(7'h7F, 7'b0001110, 7'b0000110), "sub_brw");
`endif
        do_op(3'b101, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, mk3(7'h7F, 7'b1000000, 7'b1000000), "sub_eq");
        do_op(3'b000, 8'h6A, 8'h00, 8'h95, 1'b0, 1'b0, mk3(7'h7F, 7'b0010000, 7'b0010010), "not");
        do_op(3'b111, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0, mk3(7'h7F, 7'b0011001, 7'b1000000), "shr");
        do_op(3'b110, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, mk3(7'h7F, 7'b1000000, 7'b0100100), "shl");
        do_op(3'b010, 8'hA0, 8'h0B, 8'hAB, 1'b0, 1'b0, mk3(7'b1111111, 7'b0001000, 7'b0000011), "or_ab");
        do_op(3'b100, 8'hCD, 8'hC0, 8'h0D, 1'b0, 1'b0, mk3(7'h7F, 7'b1000000, 7'b0100001), "xor");

        // Backpressure: result held, new request ignored until released
        do_op(3'b001, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, mk3(7'h7F, 7'b1000000, 7'b1000110), "and");
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b011; a = 8'h01; b = 8'h02;
        @(posedge clk); #1; in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("bp.latency", 64'(n), 64'd2);
        in_valid = 1'b1; opcode = 3'b000; a = 8'h55; b = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("bp.result",   64'(result),   64'h03);
            chk("bp.in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.idle", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp.accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("bp.new_result", 64'(result), 64'hAA);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;

        // Async reset while holding a result
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b011; a = 8'h12; b = 8'h34;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst2.pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2.in_ready",  64'(in_ready),  64'd1);
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.result",    64'(result),    64'd0);
        chk("rst2.hex",       64'(hex),       64'(c_HEX_RST));
        @(negedge clk); rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 6);
            opcode    = 3'($urandom);
            a         = pick();
            b         = pick();
            out_ready = $urandom_range(0, 1) != 0;
            if (i == 700) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst3.out_valid", 64'(out_valid), 64'd0);
                chk("rst3.in_ready",  64'(in_ready),  64'd1);
                @(negedge clk); rst_n = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
